fetch_stage: RTL

//   Instruction-fetch stage of the 5-stage pipeline. Holds the program counter (PCF), drives
//   the word address into the instruction memory, and captures the returned instruction

---
 rtl/fetch_stage.sv | 102 ++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, instruction-memory addressing and the
// IF/ID pipeline register, with stall, flush, branch redirect and end-of-program halt.
module fetch_stage #(
  parameter int              WL       = 32,
  parameter int              IM_DEPTH = 13,
  parameter logic [WL-1:0]   RESET_PC = '0
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          StallF,
  input  logic          StallD,
  input  logic          FlushD,
  input  logic          PCSrcD,
  input  logic [WL-1:0] PCBranchD,
  output logic [WL-1:0] IMA,
  input  logic [WL-1:0] IMRD,
  output logic [WL-1:0] InstrD,
  output logic [WL-1:0] PCD,
  output logic [WL-1:0] PCPlus1D,
  output logic          ValidD,
  output logic          HaltF
);

  localparam logic [WL-1:0] IM_LIMIT = WL'(IM_DEPTH);
  localparam logic [WL-1:0] ONE      = WL'(1);

  logic [WL-1:0] pcf_q, pcf_d;
  logic [WL-1:0] instr_q, instr_d;
  logic [WL-1:0] pcd_q, pcd_d;
  logic [WL-1:0] pc_plus1_q, pc_plus1_d;
  logic          valid_q, valid_d;

  logic          halt_f;
  logic [WL-1:0] pcf_plus1;
  logic [WL-1:0] fetch_instr;

  // Once the PC runs off the end of the program, fetch is parked and emits bubbles.
  assign halt_f      = (pcf_q >= IM_LIMIT);
  assign pcf_plus1   = pcf_q + ONE;
  assign fetch_instr = halt_f ? '0 : IMRD;

  assign IMA      = pcf_q;
  assign HaltF    = halt_f;
  assign InstrD   = instr_q;
  assign PCD      = pcd_q;
  assign PCPlus1D = pc_plus1_q;
  assign ValidD   = valid_q;

  // A stalled PC ignores a redirect; the hazard unit re-presents it later.
  always_comb begin
    pcf_d = pcf_q;
    if (StallF) begin
      pcf_d = pcf_q;
    end else if (PCSrcD) begin
      pcf_d = PCBranchD;
    end else if (halt_f) begin
      pcf_d = pcf_q;
    end else begin
      pcf_d = pcf_plus1;
    end
  end

  always_comb begin
    instr_d    = instr_q;
    pcd_d      = pcd_q;
    pc_plus1_d = pc_plus1_q;
    valid_d    = valid_q;
    if (StallD) begin
      instr_d    = instr_q;
      pcd_d      = pcd_q;
      pc_plus1_d = pc_plus1_q;
      valid_d    = valid_q;
    end else if (FlushD) begin
      instr_d    = '0;
      pcd_d      = '0;
      pc_plus1_d = '0;
      valid_d    = 1'b0;
    end else begin
      instr_d    = fetch_instr;
      pcd_d      = pcf_q;
      pc_plus1_d = pcf_plus1;
      valid_d    = ~halt_f;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pcf_q      <= RESET_PC;
      instr_q    <= '0;
      pcd_q      <= '0;
      pc_plus1_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      pcf_q      <= pcf_d;
      instr_q    <= instr_d;
      pcd_q      <= pcd_d;
      pc_plus1_q <= pc_plus1_d;
      valid_q    <= valid_d;
    end
  end

endmodule
